// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32I load/store unit driving a req/gnt/rvalid data port.
// Ports: sequencer start/busy/done/err, decode in, rdata_o, mem_* port.
module lsu_mem_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        data_read_i,
  input  logic        write_en_DMEM_i,
  input  logic [2:0]  load_type_i,
  input  logic [1:0]  store_type_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_R,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [2:0]       r_ltype;
  logic [1:0]       r_stype;
  logic             r_is_load;
  logic             r_err;
  logic [31:0]      r_rdata;
  logic [CNT_W-1:0] r_cnt;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_tmo_hit;
  logic             w_cap;
  logic             w_tmo;
  logic             w_upd;

  // Legality of the access presented with start_i
  logic w_ld_b, w_ld_h, w_ld_w;
  logic w_ty_ok, w_mis, w_illegal;

  assign w_ld_b = (load_type_i == 3'd1) | (load_type_i == 3'd4);
  assign w_ld_h = (load_type_i == 3'd2) | (load_type_i == 3'd5);
  assign w_ld_w = (load_type_i == 3'd3);

  always_comb begin
    w_ty_ok = 1'b0;
    w_mis   = 1'b0;
    if (data_read_i) begin
      w_ty_ok = w_ld_b | w_ld_h | w_ld_w;
      w_mis   = (w_ld_h & addr_i[0]) | (w_ld_w & (|addr_i[1:0]));
    end else begin
      w_ty_ok = (store_type_i != 2'd0);
      w_mis   = ((store_type_i == 2'd2) & addr_i[0])
              | ((store_type_i == 2'd3) & (|addr_i[1:0]));
    end
  end

  // Exactly one direction must be selected
  assign w_illegal = ~(data_read_i ^ write_en_DMEM_i) | ~w_ty_ok | w_mis;

  // Lane pattern from the captured access
  logic [1:0]  w_off;
  logic        w_sz_b, w_sz_h;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  assign w_off  = r_addr[1:0];
  assign w_sz_b = r_is_load
                ? ((r_ltype == 3'd1) | (r_ltype == 3'd4))
                : (r_stype == 2'd1);
  assign w_sz_h = r_is_load
                ? ((r_ltype == 3'd2) | (r_ltype == 3'd5))
                : (r_stype == 2'd2);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_wdata;
    if (w_sz_b) begin
      w_be    = 4'b0001 << w_off;
      w_wdata = {4{r_wdata[7:0]}};
    end else if (w_sz_h) begin
      w_be    = w_off[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{r_wdata[15:0]}};
    end
  end

  // Load data extraction
  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  assign w_shift = mem_rdata_i >> {w_off, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = w_off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

  always_comb begin
    w_ext = mem_rdata_i;
    unique case (r_ltype)
      3'd1:    w_ext = {{24{w_byte[7]}}, w_byte};
      3'd2:    w_ext = {{16{w_half[15]}}, w_half};
      3'd4:    w_ext = {24'd0, w_byte};
      3'd5:    w_ext = {16'd0, w_half};
      default: w_ext = mem_rdata_i;
    endcase
  end

  // Timeout fires on the cycle the wait count would reach the limit
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_tmo_hit = TO_EN && (w_cnt_inc == TO_VAL);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cap       = 1'b0;
    w_tmo       = 1'b0;
    w_upd       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_cap       = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = w_illegal ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_gnt_i) begin
          w_cnt_nxt   = '0;
          w_state_nxt = r_is_load ? S_WAIT_R : S_DONE;
        end else if (w_tmo_hit) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_WAIT_R: begin
        if (mem_rvalid_i) begin
          w_upd       = 1'b1;
          w_state_nxt = S_DONE;
        end else if (w_tmo_hit) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_DONE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_ltype   <= '0;
      r_stype   <= '0;
      r_is_load <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_cnt     <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_cap) begin
        r_addr    <= addr_i;
        r_wdata   <= wdata_i;
        r_ltype   <= load_type_i;
        r_stype   <= store_type_i;
        r_is_load <= data_read_i;
        r_err     <= w_illegal;
      end
      if (w_tmo) r_err <= 1'b1;
      if (w_upd) r_rdata <= w_ext;
    end
  end

  logic w_in_req;
  logic w_in_done;

  assign w_in_req  = (r_state == S_REQ);
  assign w_in_done = (r_state == S_DONE);

  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = w_in_done;
  assign err_o       = w_in_done & r_err;
  assign rdata_o     = r_rdata;
  assign mem_req_o   = w_in_req;
  assign mem_we_o    = w_in_req & ~r_is_load;
  assign mem_addr_o  = w_in_req ? {r_addr[31:2], 2'b00} : 32'd0;
  assign mem_be_o    = w_in_req ? w_be : 4'd0;
  assign mem_wdata_o = (w_in_req & ~r_is_load) ? w_wdata : 32'd0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed self-checking bench for lsu_mem_ctrl.
// Zero-wait accesses, illegal accesses, timeouts and async reset.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        dr;
  logic        we;
  logic [2:0]  lt;
  logic [1:0]  st;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        req, mwe;
  logic [31:0] maddr;
  logic [3:0]  be;
  logic [31:0] mwdata;
  logic        gnt, rvalid;
  logic [31:0] mrdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(
    .TIMEOUT_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(start),
    .data_read_i(dr),
    .write_en_DMEM_i(we),
    .load_type_i(lt),
    .store_type_i(st),
    .addr_i(addr),
    .wdata_i(wdata),
    .busy_o(busy),
    .done_o(done),
    .err_o(err),
    .rdata_o(rdata),
    .mem_req_o(req),
    .mem_we_o(mwe),
    .mem_addr_o(maddr),
    .mem_be_o(be),
    .mem_wdata_o(mwdata),
    .mem_gnt_i(gnt),
    .mem_rvalid_i(rvalid),
    .mem_rdata_i(mrdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic r, input logic w, input logic [2:0] l,
                    input logic [1:0] s, input logic [31:0] a,
                    input logic [31:0] d);
    start = 1'b1;
    dr    = r;
    we    = w;
    lt    = l;
    st    = s;
    addr  = a;
    wdata = d;
    cyc();
    start = 1'b0;
    dr    = 1'b0;
    we    = 1'b0;
    lt    = 3'd0;
    st    = 2'd0;
    addr  = 32'hFFFF_FFFF;
    wdata = 32'h0;
  endtask

  task automatic run_load(input string tag, input logic [2:0] l,
                          input logic [31:0] a, input logic [31:0] md,
                          input logic [3:0] exp_be,
                          input logic [31:0] exp_rd);
    go(1'b1, 1'b0, l, 2'd0, a, 32'h0);
    chk({tag, "_req"}, 32'(req), 32'd1);
    chk({tag, "_we"}, 32'(mwe), 32'd0);
    chk({tag, "_addr"}, maddr, {a[31:2], 2'b00});
    chk({tag, "_be"}, 32'(be), 32'(exp_be));
    gnt = 1'b1;
    cyc();
    gnt = 1'b0;
    chk({tag, "_wait_req"}, 32'(req), 32'd0);
    chk({tag, "_wait_done"}, 32'(done), 32'd0);
    rvalid = 1'b1;
    mrdata = md;
    cyc();
    rvalid = 1'b0;
    mrdata = 32'h0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_rdata"}, rdata, exp_rd);
    cyc();
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    rst    = 1'b1;
    start  = 1'b0;
    dr     = 1'b0;
    we     = 1'b0;
    lt     = 3'd0;
    st     = 2'd0;
    addr   = 32'h0;
    wdata  = 32'h0;
    gnt    = 1'b0;
    rvalid = 1'b0;
    mrdata = 32'h0;
    cyc();
    cyc();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_addr", maddr, 32'd0);
    chk("rst_be", 32'(be), 32'd0);
    rst = 1'b0;
    cyc();

    // SB at 0x1003
    go(1'b0, 1'b1, 3'd0, 2'd1, 32'h0000_1003, 32'h0000_00A5);
    chk("sb_req", 32'(req), 32'd1);
    chk("sb_we", 32'(mwe), 32'd1);
    chk("sb_addr", maddr, 32'h0000_1000);
    chk("sb_be", 32'(be), 32'h8);
    chk("sb_wdata", mwdata, 32'hA5A5_A5A5);
    gnt = 1'b1;
    cyc();
    gnt = 1'b0;
    chk("sb_done", 32'(done), 32'd1);
    chk("sb_err", 32'(err), 32'd0);
    chk("sb_req_off", 32'(req), 32'd0);
    cyc();
    chk("sb_done_pulse", 32'(done), 32'd0);
    chk("sb_idle", 32'(busy), 32'd0);

    run_load("lb", 3'd1, 32'h0000_2001, 32'h0000_80FF, 4'b0010,
             32'hFFFF_FF80);
    run_load("lbu", 3'd4, 32'h0000_2001, 32'h0000_80FF, 4'b0010,
             32'h0000_0080);
    run_load("lh", 3'd2, 32'h0000_3002, 32'h7FFF_0000, 4'b1100,
             32'h0000_7FFF);
    run_load("lhu", 3'd5, 32'h0000_3000, 32'h1234_8001, 4'b0011,
             32'h0000_8001);

    // Misaligned LW: no request, err, rdata kept
    go(1'b1, 1'b0, 3'd3, 2'd0, 32'h0000_3006, 32'h0);
    chk("lwmis_done", 32'(done), 32'd1);
    chk("lwmis_err", 32'(err), 32'd1);
    chk("lwmis_req", 32'(req), 32'd0);
    chk("lwmis_rdata", rdata, 32'h0000_8001);
    cyc();
    chk("lwmis_idle", 32'(busy), 32'd0);

    // SW timeout in REQ
    go(1'b0, 1'b1, 3'd0, 2'd3, 32'h0000_4000, 32'h1234_5678);
    chk("sw_be", 32'(be), 32'hF);
    chk("sw_wdata", mwdata, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tor_req%0d", i), 32'(req), 32'd1);
      cyc();
    end
    chk("tor_done", 32'(done), 32'd1);
    chk("tor_err", 32'(err), 32'd1);
    chk("tor_req_off", 32'(req), 32'd0);
    cyc();

    // LW timeout in WAIT_R
    go(1'b1, 1'b0, 3'd3, 2'd0, 32'h0000_5000, 32'h0);
    chk("tow_req", 32'(req), 32'd1);
    gnt = 1'b1;
    cyc();
    gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tow_busy%0d", i), 32'(busy), 32'd1);
      chk($sformatf("tow_nd%0d", i), 32'(done), 32'd0);
      cyc();
    end
    chk("tow_done", 32'(done), 32'd1);
    chk("tow_err", 32'(err), 32'd1);
    chk("tow_rdata", rdata, 32'h0000_8001);
    cyc();

    // Async reset in WAIT_R
    go(1'b1, 1'b0, 3'd3, 2'd0, 32'h0000_6000, 32'h0);
    gnt = 1'b1;
    cyc();
    gnt = 1'b0;
    chk("ar_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_rdata", rdata, 32'd0);
    chk("ar_req", 32'(req), 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    rvalid = 1'b1;
    mrdata = 32'hDEAD_BEEF;
    cyc();
    rvalid = 1'b0;
    chk("ar_post_rdata", rdata, 32'd0);
    chk("ar_post_busy", 32'(busy), 32'd0);
    chk("ar_post_done", 32'(done), 32'd0);

    // Both directions set
    go(1'b1, 1'b1, 3'd3, 2'd3, 32'h0000_0000, 32'h0);
    chk("both_done", 32'(done), 32'd1);
    chk("both_err", 32'(err), 32'd1);
    chk("both_req", 32'(req), 32'd0);
    cyc();

    // Store type 0
    go(1'b0, 1'b1, 3'd0, 2'd0, 32'h0000_0000, 32'h0);
    chk("st0_done", 32'(done), 32'd1);
    chk("st0_err", 32'(err), 32'd1);
    chk("st0_req", 32'(req), 32'd0);
    cyc();

    // SH with a second start while busy
    go(1'b0, 1'b1, 3'd0, 2'd2, 32'h0000_7002, 32'h0000_BEEF);
    chk("sh_be", 32'(be), 32'hC);
    chk("sh_wdata", mwdata, 32'hBEEF_BEEF);
    go(1'b1, 1'b0, 3'd3, 2'd0, 32'h0000_8000, 32'h0);
    chk("sh_still_req", 32'(req), 32'd1);
    chk("sh_still_we", 32'(mwe), 32'd1);
    chk("sh_still_addr", maddr, 32'h0000_7000);
    gnt = 1'b1;
    cyc();
    gnt = 1'b0;
    chk("sh_done", 32'(done), 32'd1);
    chk("sh_err", 32'(err), 32'd0);
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (done) dcnt++;
    end
    chk("sh_extra_done", 32'(dcnt), 32'd0);
    chk("sh_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
